// File: rtl/zom_pkg.sv
// Shared types and geometry for the zombie sprite unit.
// Optional animation is enabled with the ZOMBIE_ANIM_EN macro.
package zom_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_WALK, ST_EAT, ST_DYING} state_t;

   localparam int unsigned X_W       = 10;
   localparam int unsigned ROW_W     = 3;
   localparam int unsigned HP_W      = 4;
   localparam int unsigned FRAME_W   = 3;
   localparam int unsigned ADDR_W    = 19;

   localparam int unsigned SPR_W     = 48;
   localparam int unsigned SPR_H     = 80;
   localparam int unsigned ROW_Y0    = 80;
   localparam int unsigned ROW_PITCH = 96;
   localparam int unsigned SPAWN_X   = 640;
   localparam int unsigned HOUSE_X   = 16;
   localparam int unsigned MAX_ROW   = 4;
   localparam int unsigned FRAME_PIX = SPR_W * SPR_H;

   localparam logic [FRAME_W-1:0] FR_WALK      = 3'd0;
   localparam logic [FRAME_W-1:0] FR_WALK_LAST = 3'd3;
   localparam logic [FRAME_W-1:0] FR_EAT       = 3'd4;
   localparam logic [FRAME_W-1:0] FR_EAT_LAST  = 3'd5;
   localparam logic [FRAME_W-1:0] FR_DIE       = 3'd6;

   function automatic logic [FRAME_W-1:0] first_frame(input state_t s);
      case (s)
         ST_EAT:   return FR_EAT;
         ST_DYING: return FR_DIE;
         default:  return FR_WALK;
      endcase
   endfunction

   // Cycle within the state's frame range; DYING holds a single frame.
   function automatic logic [FRAME_W-1:0] next_frame(input state_t s, input logic [FRAME_W-1:0] f);
      if (s == ST_WALK) return (f == FR_WALK_LAST) ? FR_WALK : f + FRAME_W'(1);
      if (s == ST_EAT)  return (f == FR_EAT_LAST) ? FR_EAT : FR_EAT_LAST;
      return f;
   endfunction

endpackage

// File: rtl/zom_addr_gen.sv
// Pixel hit-test against the zombie sprite box and sprite-ROM address generation.
module zom_addr_gen
   import zom_pkg::*;
(
   input  logic               visible,
   input  logic [X_W-1:0]     draw_x,
   input  logic [X_W-1:0]     draw_y,
   input  logic [X_W-1:0]     pos_x,
   input  logic [ROW_W-1:0]   row,
   input  logic [FRAME_W-1:0] frame,
   output logic               zom_on_c,
   output logic [ADDR_W-1:0]  address_c
);

   logic [ADDR_W-1:0] px, py, ox, oy, dx, dy;
   logic              in_x, in_y;

   always_comb begin
      px   = ADDR_W'(draw_x);
      py   = ADDR_W'(draw_y);
      ox   = ADDR_W'(pos_x);
      oy   = ADDR_W'(ROW_Y0) + ADDR_W'(row) * ADDR_W'(ROW_PITCH);
      dx   = px - ox;
      dy   = py - oy;
      in_x = (px >= ox) && (px < ox + ADDR_W'(SPR_W));
      in_y = (py >= oy) && (py < oy + ADDR_W'(SPR_H));
      zom_on_c  = visible && in_x && in_y;
      address_c = '0;
      if (zom_on_c)
         address_c = ADDR_W'(frame) * ADDR_W'(FRAME_PIX) + dy * ADDR_W'(SPR_W) + dx;
   end

endmodule

// File: rtl/zombie_unit.sv
// Single zombie: spawn, walk left, eat blocking plant, die on hits, animate sprite.
// Define ZOMBIE_ANIM_EN to cycle animation frames; otherwise each state shows a fixed frame.
module zombie_unit
   import zom_pkg::*;
#(
   parameter int unsigned HEALTH_INIT = 10,
   parameter int unsigned WALK_DIV    = 2,
   parameter int unsigned BITE_DIV    = 32,
   parameter int unsigned DIE_FRAMES  = 32,
   parameter int unsigned ANIM_DIV    = 8
)(
   input  logic               MAX10_CLK1_50,
   input  logic               Reset_n,
   input  logic               frame_clk,
   input  logic               spawn,
   input  logic [ROW_W-1:0]   spawn_row,
   input  logic               hit,
   input  logic               blocked,
   input  logic [X_W-1:0]     DrawX,
   input  logic [X_W-1:0]     DrawY,
   output logic               zom_on,
   output logic [ADDR_W-1:0]  address,
   output logic [X_W-1:0]     zom_x,
   output logic [ROW_W-1:0]   zom_row,
   output logic               active,
   output logic               bite,
   output logic               reached_house
);

   localparam int unsigned WALK_CW = $clog2(WALK_DIV + 1);
   localparam int unsigned BITE_CW = $clog2(BITE_DIV + 1);
   localparam int unsigned DIE_CW  = $clog2(DIE_FRAMES + 1);
   localparam int unsigned ANIM_CW = $clog2(ANIM_DIV + 1);

   if (HEALTH_INIT < 1 || HEALTH_INIT > 15 || WALK_DIV == 0 || BITE_DIV == 0 ||
       DIE_FRAMES == 0 || ANIM_DIV == 0 || ANIM_CW == 0) begin : g_bad_param
      $error("zombie_unit: parameter out of range");
   end

   state_t               state;
   logic                 fclk_q;
   logic [HP_W-1:0]      health;
   logic [WALK_CW-1:0]   walk_cnt;
   logic [BITE_CW-1:0]   bite_cnt;
   logic [DIE_CW-1:0]    die_cnt;
   logic [FRAME_W-1:0]   frame;
   logic                 tick_c;
   logic                 kill_c;

   assign tick_c = frame_clk & ~fclk_q;
   assign kill_c = hit && (health <= HP_W'(1));

   // Main FSM; a lethal hit wins over house/bite events in the same cycle.
   always_ff @(posedge MAX10_CLK1_50 or negedge Reset_n) begin
      if (!Reset_n) begin
         fclk_q        <= 1'b0;
         state         <= ST_IDLE;
         zom_x         <= X_W'(SPAWN_X);
         zom_row       <= '0;
         health        <= '0;
         walk_cnt      <= '0;
         bite_cnt      <= '0;
         die_cnt       <= '0;
         active        <= 1'b0;
         bite          <= 1'b0;
         reached_house <= 1'b0;
      end else begin
         fclk_q        <= frame_clk;
         bite          <= 1'b0;
         reached_house <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (spawn && (spawn_row <= ROW_W'(MAX_ROW))) begin
                  state    <= ST_WALK;
                  active   <= 1'b1;
                  zom_x    <= X_W'(SPAWN_X);
                  zom_row  <= spawn_row;
                  health   <= HP_W'(HEALTH_INIT);
                  walk_cnt <= '0;
                  bite_cnt <= '0;
                  die_cnt  <= '0;
               end
            end
            ST_WALK: begin
               if (kill_c) begin
                  state   <= ST_DYING;
                  health  <= '0;
                  die_cnt <= '0;
               end else begin
                  if (hit) health <= health - HP_W'(1);
                  if (zom_x <= X_W'(HOUSE_X)) begin
                     reached_house <= 1'b1;
                     state         <= ST_IDLE;
                     active        <= 1'b0;
                  end else if (blocked) begin
                     state    <= ST_EAT;
                     bite_cnt <= '0;
                  end else if (tick_c) begin
                     if (walk_cnt == WALK_CW'(WALK_DIV - 1)) begin
                        walk_cnt <= '0;
                        zom_x    <= zom_x - X_W'(1);
                     end else begin
                        walk_cnt <= walk_cnt + WALK_CW'(1);
                     end
                  end
               end
            end
            ST_EAT: begin
               if (kill_c) begin
                  state   <= ST_DYING;
                  health  <= '0;
                  die_cnt <= '0;
               end else begin
                  if (hit) health <= health - HP_W'(1);
                  if (!blocked) begin
                     state    <= ST_WALK;
                     bite_cnt <= '0;
                  end else if (tick_c) begin
                     if (bite_cnt == BITE_CW'(BITE_DIV - 1)) begin
                        bite_cnt <= '0;
                        bite     <= 1'b1;
                     end else begin
                        bite_cnt <= bite_cnt + BITE_CW'(1);
                     end
                  end
               end
            end
            ST_DYING: begin
               if (tick_c) begin
                  if (die_cnt == DIE_CW'(DIE_FRAMES - 1)) begin
                     die_cnt <= '0;
                     state   <= ST_IDLE;
                     active  <= 1'b0;
                  end else begin
                     die_cnt <= die_cnt + DIE_CW'(1);
                  end
               end
            end
            default: begin
               state  <= ST_IDLE;
               active <= 1'b0;
            end
         endcase
      end
   end

`ifdef ZOMBIE_ANIM_EN
   state_t               anim_state;
   logic [FRAME_W-1:0]   anim_frame;
   logic [ANIM_CW-1:0]   anim_cnt;

   // A state mismatch marks the first cycle of a new state: restart its frame sequence.
   always_ff @(posedge MAX10_CLK1_50 or negedge Reset_n) begin
      if (!Reset_n) begin
         anim_state <= ST_IDLE;
         anim_frame <= FR_WALK;
         anim_cnt   <= '0;
      end else if (state != anim_state) begin
         anim_state <= state;
         anim_frame <= first_frame(state);
         anim_cnt   <= '0;
      end else if (tick_c && (state == ST_WALK || state == ST_EAT)) begin
         if (anim_cnt == ANIM_CW'(ANIM_DIV - 1)) begin
            anim_cnt   <= '0;
            anim_frame <= next_frame(state, anim_frame);
         end else begin
            anim_cnt <= anim_cnt + ANIM_CW'(1);
         end
      end
   end

   assign frame = (state != anim_state) ? first_frame(state) : anim_frame;
`else
   assign frame = first_frame(state);
`endif

   zom_addr_gen u_addr_gen (
      .visible   (state != ST_IDLE),
      .draw_x    (DrawX),
      .draw_y    (DrawY),
      .pos_x     (zom_x),
      .row       (zom_row),
      .frame     (frame),
      .zom_on_c  (zom_on),
      .address_c (address)
   );

endmodule
